cursor_commit_ctrl: RTL and testbench

Frame-synchronous scheduler for the cursor overlay position. It accepts position/button updates from the mouse side over a req/ack handshake, holds the newest one in a shadow register, and commits it to the overlay inputs (xpos/ypos feeding the mouse display stage) only on the rising edge of vertical blanking. The cursor therefore never moves mid-frame and never tears. It sits between the mouse decoder and the sync-delay/overlay stage, all in the pclk domain.

---
 rtl/cursor_commit_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_cursor_commit_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_commit_ctrl.sv
// cursor_commit_ctrl
// Frame-synchronous cursor position scheduler. Mouse-side updates are
// captured over a req/ack handshake into a shadow register. The newest
// shadow is committed to the overlay position on the rising edge of
// vertical blanking, so the cursor never moves mid-frame.
//
// Capture:  upd_req & ~upd_ack at a clock edge. The ack cycle masks req,
//           which limits the source to one capture every two cycles.
// Commit:   vblnk rising edge while an update is pending and not frozen.
// Buttons:  OR-accumulated in the shadow so short clicks survive
//           overwrites. On the committed side they last one frame.
module cursor_commit_ctrl #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        i_upd_req,
  output logic        o_upd_ack,
  input  logic [11:0] i_xpos_in,
  input  logic [11:0] i_ypos_in,
  input  logic [2:0]  i_btn_in,
  input  logic        i_vblnk,
  input  logic        i_freeze,
  output logic [11:0] o_xpos,
  output logic [11:0] o_ypos,
  output logic [2:0]  o_btn,
  output logic        o_commit_stb,
  output logic        o_pending,
  output logic [15:0] o_frame_cnt,
  output logic [7:0]  o_drop_cnt
);

  localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - 1);
  localparam logic [7:0]  DROP_MAX = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // FSM state
  state_t      r_state;
  state_t      w_state_next;

  // Edge detector. Resets high so a vblnk already high at reset release
  // is not mistaken for a new frame.
  logic        r_vblnk_q;

  // Shadow holding the newest uncommitted update
  logic [11:0] r_sx;
  logic [11:0] r_sy;
  logic [2:0]  r_sbtn;
  logic [11:0] w_sx_next;
  logic [11:0] w_sy_next;
  logic [2:0]  w_sbtn_next;

  // Committed (overlay-side) registers
  logic        r_upd_ack;
  logic [11:0] r_xpos;
  logic [11:0] r_ypos;
  logic [2:0]  r_btn;
  logic        r_commit_stb;
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_drop_cnt;
  logic [11:0] w_xpos_next;
  logic [11:0] w_ypos_next;
  logic [2:0]  w_btn_next;
  logic [7:0]  w_drop_cnt_next;

  // Event decode
  logic        w_vb_rise;
  logic        w_capture;
  logic        w_commit;
  logic        w_is_pend;
  logic [11:0] w_x_clamped;
  logic [11:0] w_y_clamped;

  assign w_is_pend   = (r_state == ST_PEND);
  assign w_vb_rise   = i_vblnk & ~r_vblnk_q;
  // The ack cycle masks req: the source is still showing the data that
  // was just captured and only changes it after seeing the ack.
  assign w_capture   = i_upd_req & ~r_upd_ack;
  assign w_commit    = w_vb_rise & w_is_pend & ~i_freeze;

  // Unsigned clamp into the visible area
  assign w_x_clamped = (i_xpos_in > X_MAX) ? X_MAX : i_xpos_in;
  assign w_y_clamped = (i_ypos_in > Y_MAX) ? Y_MAX : i_ypos_in;

  // Next state: any capture leaves us pending; a commit alone drains us
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_capture) begin
          w_state_next = ST_PEND;
        end else if (w_commit) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Shadow next value. On a collision the commit reads the old shadow,
  // so the fresh capture starts a clean button accumulation.
  always_comb begin
    w_sx_next   = r_sx;
    w_sy_next   = r_sy;
    w_sbtn_next = r_sbtn;
    if (w_capture) begin
      w_sx_next = w_x_clamped;
      w_sy_next = w_y_clamped;
      if (w_commit) begin
        w_sbtn_next = i_btn_in;
      end else begin
        w_sbtn_next = r_sbtn | i_btn_in;
      end
    end else if (w_commit) begin
      w_sbtn_next = 3'b000;
    end
  end

  // Overlay-side next value: load on commit, drop buttons on an empty frame
  always_comb begin
    w_xpos_next = r_xpos;
    w_ypos_next = r_ypos;
    w_btn_next  = r_btn;
    if (w_commit) begin
      w_xpos_next = r_sx;
      w_ypos_next = r_sy;
      w_btn_next  = r_sbtn;
    end else if (w_vb_rise && !w_is_pend) begin
      w_btn_next  = 3'b000;
    end
  end

  // Drop counter next value: only a capture that overwrites an
  // undisplayed shadow counts; a collision with a commit does not.
  always_comb begin
    w_drop_cnt_next = r_drop_cnt;
    if (w_capture && w_is_pend && !w_commit && (r_drop_cnt != DROP_MAX)) begin
      w_drop_cnt_next = r_drop_cnt + 8'd1;
    end
  end

  // State, edge detector and shadow registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vblnk_q <= 1'b1;
      r_sx      <= '0;
      r_sy      <= '0;
      r_sbtn    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_vblnk_q <= i_vblnk;
      r_sx      <= w_sx_next;
      r_sy      <= w_sy_next;
      r_sbtn    <= w_sbtn_next;
    end
  end

  // Handshake, committed position and strobe registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_upd_ack    <= 1'b0;
      r_xpos       <= '0;
      r_ypos       <= '0;
      r_btn        <= '0;
      r_commit_stb <= 1'b0;
    end else begin
      r_upd_ack    <= w_capture;
      r_xpos       <= w_xpos_next;
      r_ypos       <= w_ypos_next;
      r_btn        <= w_btn_next;
      r_commit_stb <= w_commit;
    end
  end

  // Frame counter (wraps) and drop counter (saturates)
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_vb_rise) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      r_drop_cnt <= w_drop_cnt_next;
    end
  end

  assign o_upd_ack    = r_upd_ack;
  assign o_xpos       = r_xpos;
  assign o_ypos       = r_ypos;
  assign o_btn        = r_btn;
  assign o_commit_stb = r_commit_stb;
  assign o_pending    = r_state;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_cursor_commit_ctrl.sv
// Testbench for cursor_commit_ctrl: directed vectors, scoreboard queues
// filled by the stimulus, drained by an independent output monitor.
module tb_cursor_commit_ctrl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_req = 1'b0;
  logic        upd_ack;
  logic [11:0] xpos_in = '0;
  logic [11:0] ypos_in = '0;
  logic [2:0]  btn_in = '0;
  logic        vblnk = 1'b1;
  logic        freeze = 1'b0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [2:0]  btn;
  logic        commit_stb;
  logic        pending;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int x;
    int y;
    int b;
    int f;
  } commit_t;

  commit_t commit_q[$];
  int      ack_q[$];   // expected drop_cnt seen in the ack cycle

  cursor_commit_ctrl #(.H_ACTIVE(800), .V_ACTIVE(600)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .i_upd_req    (upd_req),
    .o_upd_ack    (upd_ack),
    .i_xpos_in    (xpos_in),
    .i_ypos_in    (ypos_in),
    .i_btn_in     (btn_in),
    .i_vblnk      (vblnk),
    .i_freeze     (freeze),
    .o_xpos       (xpos),
    .o_ypos       (ypos),
    .o_btn        (btn),
    .o_commit_stb (commit_stb),
    .o_pending    (pending),
    .o_frame_cnt  (frame_cnt),
    .o_drop_cnt   (drop_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One capture: req held for the capture edge, dropped after the ack cycle
  task automatic send(input int x, input int y, input int b, input int exp_drop);
    upd_req = 1'b1;
    xpos_in = 12'(x);
    ypos_in = 12'(y);
    btn_in  = 3'(b);
    ack_q.push_back(exp_drop);
    tick();
    upd_req = 1'b0;
    tick();
    chk("pending_after_send", int'(pending), 1);
  endtask

  // One vertical blanking pulse, optionally expecting a commit
  task automatic vb_pulse(input bit exp_commit, input int x, input int y,
                          input int b, input int f);
    commit_t c;
    vblnk = 1'b1;
    if (exp_commit) begin
      c.x = x; c.y = y; c.b = b; c.f = f;
      commit_q.push_back(c);
    end
    repeat (3) tick();
    vblnk = 1'b0;
    repeat (2) tick();
    chk("frame_cnt", int'(frame_cnt), f);
  endtask

  // Monitor: compares every ack / commit the DUT presents against the queues
  initial begin
    int      ed;
    commit_t ec;
    forever begin
      @(negedge pclk);
      if (upd_ack === 1'b1) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          ed = ack_q.pop_front();
          chk("ack_drop_cnt", int'(drop_cnt), ed);
          chk("ack_pending", int'(pending), 1);
        end
      end
      if (commit_stb === 1'b1) begin
        if (commit_q.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          ec = commit_q.pop_front();
          chk("commit_xpos", int'(xpos), ec.x);
          chk("commit_ypos", int'(ypos), ec.y);
          chk("commit_btn", int'(btn), ec.b);
          chk("commit_frame", int'(frame_cnt), ec.f);
        end
      end
    end
  end

  initial begin
    // Reset with vblnk high, keep it high after release: no frame edge
    rst   = 1'b1;
    vblnk = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_xpos", int'(xpos), 0);
    chk("rst_ypos", int'(ypos), 0);
    chk("rst_btn", int'(btn), 0);
    chk("rst_commit_stb", int'(commit_stb), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_upd_ack", int'(upd_ack), 0);
    vblnk = 1'b0;
    repeat (3) tick();

    // Single update, then an empty frame clears btn but keeps position
    send(100, 50, 1, 0);
    repeat (4) tick();
    vb_pulse(1'b1, 100, 50, 1, 1);
    chk("single_pending_clear", int'(pending), 0);
    vb_pulse(1'b0, 0, 0, 0, 2);
    chk("empty_btn_clear", int'(btn), 0);
    chk("empty_xpos_hold", int'(xpos), 100);

    // Clamp
    send(900, 4095, 0, 0);
    vb_pulse(1'b1, 799, 599, 0, 3);
    send(799, 10, 0, 0);
    vb_pulse(1'b1, 799, 10, 0, 4);

    // Overwrites in one frame: latest position, OR'd buttons
    send(10, 10, 1, 0);
    send(20, 20, 4, 1);
    send(30, 30, 0, 2);
    vb_pulse(1'b1, 30, 30, 5, 5);
    chk("overwrite_drop_cnt", int'(drop_cnt), 2);

    // Collision: capture on the vb_rise edge
    send(5, 5, 2, 2);
    repeat (2) tick();
    begin
      commit_t c;
      c.x = 5; c.y = 5; c.b = 2; c.f = 6;
      commit_q.push_back(c);
    end
    ack_q.push_back(2);
    vblnk   = 1'b1;
    upd_req = 1'b1;
    xpos_in = 12'd6;
    ypos_in = 12'd6;
    btn_in  = 3'd1;
    tick();
    upd_req = 1'b0;
    tick();
    chk("collision_pending", int'(pending), 1);
    chk("collision_drop_cnt", int'(drop_cnt), 2);
    tick();
    vblnk = 1'b0;
    repeat (2) tick();
    vb_pulse(1'b1, 6, 6, 1, 7);
    chk("collision_pending_clear", int'(pending), 0);
    chk("collision_drop_final", int'(drop_cnt), 2);

    // Drop counter saturation
    for (int k = 1; k <= 300; k++) begin
      send(k, k, 0, (k + 1 > 255) ? 255 : k + 1);
    end
    vb_pulse(1'b1, 300, 300, 0, 8);
    chk("drop_saturated", int'(drop_cnt), 255);

    // Freeze holds the pending shadow across two frames
    send(40, 40, 0, 255);
    freeze = 1'b1;
    vb_pulse(1'b0, 0, 0, 0, 9);
    vb_pulse(1'b0, 0, 0, 0, 10);
    chk("freeze_pending", int'(pending), 1);
    chk("freeze_xpos_hold", int'(xpos), 300);
    freeze = 1'b0;
    vb_pulse(1'b1, 40, 40, 0, 11);

    // Reset while pending discards the shadow
    send(50, 50, 0, 255);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_pending", int'(pending), 0);
    chk("midrst_frame_cnt", int'(frame_cnt), 0);
    chk("midrst_drop_cnt", int'(drop_cnt), 0);
    vb_pulse(1'b0, 0, 0, 0, 1);
    chk("midrst_xpos", int'(xpos), 0);

    repeat (3) tick();
    chk("ack_queue_empty", ack_q.size(), 0);
    chk("commit_queue_empty", commit_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
